// File: rtl/complex_fu_wb_pipe_pkg.sv
// complex_fu_wb_pipe_pkg: shared ALU/writeback widths, execution flag bit positions and the writeback packet type
package complex_fu_wb_pipe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int FLAG_W_DEF = 6;
  localparam int TAG_W_DEF = 7;
  localparam int ALID_W_DEF = 7;
  localparam int FLAG_EXECUTED = 0;
  localparam int FLAG_EXCEPTION = 1;
  localparam int FLAG_MISPREDICT = 2;
  typedef struct packed {
    logic [2*DATA_W_DEF-1:0] result;
    logic [FLAG_W_DEF-1:0] flags;
    logic [TAG_W_DEF-1:0] tag;
    logic [ALID_W_DEF-1:0] alid;
  } wb_pkt_t;
endpackage

// File: rtl/complex_fu_wb_pipe_stage.sv
// complex_fu_wb_pipe_stage: one pipe slot {v, pkt}; clr beats ld_in beats ld_prev, otherwise hold
module complex_fu_wb_pipe_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         ld_in,
  input  logic         ld_prev,
  input  logic         prev_v,
  input  logic [W-1:0] prev_pkt,
  input  logic [W-1:0] in_pkt,
  output logic         v,
  output logic [W-1:0] pkt
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v <= 1'b0;
      pkt <= '0;
    end else if (clr) v <= 1'b0;
    else if (ld_in) begin
      v <= 1'b1;
      pkt <= in_pkt;
    end else if (ld_prev) begin
      v <= prev_v;
      pkt <= prev_pkt;
    end
endmodule

// File: rtl/complex_fu_wb_pipe.sv
// complex_fu_wb_pipe: fixed-latency mul/div writeback pipe; valid/ready in (ALU) and out (writeback), flush kills all in-flight packets
module complex_fu_wb_pipe import complex_fu_wb_pipe_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FLAG_W = FLAG_W_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int ALID_W = ALID_W_DEF,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                valid_i,
  input  logic                is_div_i,
  input  logic [2*DATA_W-1:0] result_i,
  input  logic [FLAG_W-1:0]   flags_i,
  input  logic [TAG_W-1:0]    tag_i,
  input  logic [ALID_W-1:0]   alid_i,
  output logic                ready_o,
  input  logic                flush_i,
  output logic                valid_o,
  output logic [2*DATA_W-1:0] result_o,
  output logic [FLAG_W-1:0]   flags_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic [ALID_W-1:0]   alid_o,
  input  logic                wb_ready_i,
  output logic                busy_o
);
  localparam int PKT_W = 2*DATA_W + FLAG_W + TAG_W + ALID_W;
  localparam int K = DIV_LAT - MUL_LAT + 1;
  logic [DIV_LAT:0] v;
  logic [PKT_W-1:0] pkt [DIV_LAT+1];
  logic [PKT_W-1:0] in_pkt;
  logic adv, acc;
  assign v[0] = 1'b0;
  assign pkt[0] = '0;
  assign in_pkt = {result_i, flags_i, tag_i, alid_i};
  assign adv = !v[DIV_LAT] | wb_ready_i;
  // a multiply lands in s[K] and would overwrite whatever shifts in from s[K-1]
  assign ready_o = adv & (is_div_i | !v[K-1]);
  assign acc = valid_i & ready_o;
  for (genvar k = 1; k <= DIV_LAT; k++) begin : g_stage
    complex_fu_wb_pipe_stage #(.W(PKT_W)) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (flush_i),
      .ld_in    (acc & (is_div_i ? k == 1 : k == K)),
      .ld_prev  (adv),
      .prev_v   (v[k-1]),
      .prev_pkt (pkt[k-1]),
      .in_pkt   (in_pkt),
      .v        (v[k]),
      .pkt      (pkt[k])
    );
  end
  assign valid_o = v[DIV_LAT];
  assign {result_o, flags_o, tag_o, alid_o} = pkt[DIV_LAT];
  assign busy_o = |v[DIV_LAT:1];
endmodule

// File: tb/tb_complex_fu_wb_pipe.sv
// tb_complex_fu_wb_pipe: table-driven latency vectors, directed corner sequences and a tag-matched scoreboard
module tb_complex_fu_wb_pipe;
  import complex_fu_wb_pipe_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0;
  logic valid_i = 1'b0, is_div_i = 1'b0, flush_i = 1'b0, wb_ready_i = 1'b1;
  logic [63:0] result_i = '0;
  logic [5:0] flags_i = '0;
  logic [6:0] tag_i = '0, alid_i = '0;
  logic ready_o, valid_o, busy_o;
  logic [63:0] result_o;
  logic [5:0] flags_o;
  logic [6:0] tag_o, alid_o;
  int n_cmp = 0, n_bad = 0;
  wb_pkt_t sb[$];
  typedef struct {logic d; logic [63:0] r; logic [5:0] f; logic [6:0] t; logic [6:0] a; int lat;} vec_t;
  vec_t tbl[4];

  complex_fu_wb_pipe dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .is_div_i(is_div_i),
    .result_i(result_i), .flags_i(flags_i), .tag_i(tag_i), .alid_i(alid_i),
    .ready_o(ready_o), .flush_i(flush_i), .valid_o(valid_o), .result_o(result_o),
    .flags_o(flags_o), .tag_o(tag_o), .alid_o(alid_o), .wb_ready_i(wb_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic put(input logic vld, input logic d, input logic [6:0] t);
    valid_i = vld;
    is_div_i = d;
    tag_i = t;
    alid_i = t + 7'd40;
    result_i = {32'hA5A5_0000 + 32'(t), 32'h0F0F_0000 + 32'(t) * 3};
    flags_i = t[5:0] ^ 6'h2A;
  endtask

  // retire a delivered packet, track accepted ones, then move to the next cycle
  task automatic fin();
    int idx;
    if (valid_o && wb_ready_i) begin
      idx = -1;
      foreach (sb[i]) if (idx < 0 && sb[i].tag == tag_o) idx = i;
      if (idx < 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: tag %0d delivered but no such packet outstanding", tag_o);
      end else begin
        chk("sb_result", result_o, sb[idx].result);
        chk("sb_flags", 64'(flags_o), 64'(sb[idx].flags));
        chk("sb_alid", 64'(alid_o), 64'(sb[idx].alid));
        sb.delete(idx);
      end
    end
    if (flush_i) sb.delete();
    else if (valid_i && ready_o) sb.push_back('{result_i, flags_i, tag_i, alid_i});
    @(negedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b0, 64'h0000_0000_0000_0006, 6'h01, 7'd5, 7'd9, 3};
    tbl[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6'h3F, 7'd127, 7'd0, 8};
    tbl[2] = '{1'b0, 64'h8000_0000_0000_0001, 6'h20, 7'd0, 7'd127, 3};
    tbl[3] = '{1'b1, 64'h0123_4567_89AB_CDEF, 6'h15, 7'd64, 7'd33, 8};
    @(negedge clk);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_flags", 64'(flags_o), 0);
    chk("rst_tag", 64'(tag_o), 0);
    chk("rst_alid", 64'(alid_o), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    foreach (tbl[i]) for (int c = 0; c < 11; c++) begin
      valid_i = (c == 0);
      is_div_i = tbl[i].d;
      result_i = tbl[i].r;
      flags_i = tbl[i].f;
      tag_i = tbl[i].t;
      alid_i = tbl[i].a;
      #1;
      if (c == 0) chk("tbl_ready", ready_o, 1);
      chk("tbl_valid", valid_o, c == tbl[i].lat);
      chk("tbl_busy", busy_o, c >= 1 && c <= tbl[i].lat);
      if (c == tbl[i].lat) begin
        chk("tbl_result", result_o, tbl[i].r);
        chk("tbl_flags", 64'(flags_o), 64'(tbl[i].f));
        chk("tbl_tag", 64'(tag_o), 64'(tbl[i].t));
        chk("tbl_alid", 64'(alid_o), 64'(tbl[i].a));
      end
      fin();
    end
    for (int c = 0; c < 10; c++) begin
      put(c < 2, c == 0, c == 0 ? 7'd1 : 7'd2);
      #1;
      if (c < 2) chk("ovt_ready", ready_o, 1);
      chk("ovt_valid", valid_o, c == 4 || c == 8);
      if (c == 4 || c == 8) chk("ovt_tag", 64'(tag_o), c == 4 ? 2 : 1);
      fin();
    end
    for (int c = 0; c < 11; c++) begin
      put(c == 0 || c == 5 || c == 6, c == 0, c == 0 ? 7'd3 : 7'd4);
      #1;
      if (c == 5 || c == 6) chk("col_ready", ready_o, c == 6);
      chk("col_valid", valid_o, c == 8 || c == 9);
      if (c == 8 || c == 9) chk("col_tag", 64'(tag_o), c == 8 ? 3 : 4);
      fin();
    end
    for (int c = 0; c < 10; c++) begin
      put(c == 0, 1'b0, 7'd6);
      wb_ready_i = !(c >= 3 && c <= 6);
      #1;
      chk("bp_valid", valid_o, c >= 3 && c <= 7);
      chk("bp_ready", ready_o, !(c >= 3 && c <= 6));
      if (c >= 3 && c <= 7) chk("bp_result", result_o, {32'hA5A5_0006, 32'h0F0F_0012});
      fin();
    end
    wb_ready_i = 1'b1;
    for (int c = 0; c < 9; c++) begin
      put(c <= 2 || c == 4, c <= 1, c == 4 ? 7'd7 : 7'(10 + c));
      flush_i = (c == 4);
      #1;
      chk("fl_valid", valid_o, 0);
      if (c >= 4) chk("fl_busy", busy_o, c == 4);
      fin();
    end
    for (int c = 0; c < 6; c++) begin
      put(c == 0, 1'b0, 7'd13);
      flush_i = (c == 3);
      #1;
      chk("flx_valid", valid_o, c == 3);
      if (c == 3) chk("flx_tag", 64'(tag_o), 13);
      fin();
    end
    flush_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      put(c < 2, c == 1, c == 0 ? 7'd20 : 7'd21);
      #1;
      fin();
    end
    put(1'b0, 1'b0, 7'd0);
    #1;
    chk("ar_pre_valid", valid_o, 1);
    reset_n = 1'b0;
    #1;
    chk("ar_valid", valid_o, 0);
    chk("ar_busy", busy_o, 0);
    chk("ar_tag", 64'(tag_o), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("ar_stale_valid", valid_o, 0);
      chk("ar_stale_busy", busy_o, 0);
      fin();
    end
    chk("sb_drained", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/complex_fu_wb_pipe.md
Name: complex_fu_wb_pipe

Overview:
- Sits directly downstream of the Complex ALU's combinational result and flags outputs.
- Models the fixed execution latency of multiply and divide operations, then delivers one writeback packet per cycle to the writeback/bypass stage.
- Every packet carries the 64-bit result, the execution flags, the destination physical tag and the active-list id.
- Uses a valid/ready handshake on both sides and supports a full pipeline flush on mispredict recovery.

Parameters:
- DATA_W, 32, operand width (SIZE_DATA); the result field is 2*DATA_W.
- FLAG_W, 6, execution flags width (EXECUTION_FLAGS).
- TAG_W, 7, physical register tag width.
- ALID_W, 7, active-list index width.
- MUL_LAT, 3, cycles from accept to valid_o for multiply and SYSCALL packets; legal range 1..DIV_LAT-1.
- DIV_LAT, 8, cycles from accept to valid_o for divide packets; also the pipeline depth.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- valid_i  in  1  ALU packet present.
- is_div_i  in  1  1 = divide class (DIV_LAT), 0 = multiply/other (MUL_LAT).
- result_i  in  2*DATA_W  ALU result.
- flags_i  in  FLAG_W  ALU flags.
- tag_i  in  TAG_W  destination physical tag.
- alid_i  in  ALID_W  active-list id.
- ready_o  out  1  packet accepted this cycle when valid_i & ready_o.
- flush_i  in  1  synchronous kill of all in-flight packets.
- valid_o  out  1  writeback packet valid.
- result_o  out  2*DATA_W  result field of the writeback packet.
- flags_o  out  FLAG_W  flags field of the writeback packet.
- tag_o  out  TAG_W  tag field of the writeback packet.
- alid_o  out  ALID_W  active-list id field of the writeback packet.
- wb_ready_i  in  1  writeback stage accepts the packet.
- busy_o  out  1  at least one stage valid.

Behaviour:
- Structure: stages s[1..DIV_LAT]; each stage holds {v, result, flags, tag, alid}. s[DIV_LAT] drives the *_o outputs directly (registered).
- Reset (async, reset_n=0): every s[k].v=0 and every data field 0. Resulting outputs: valid_o=0, busy_o=0, all data outputs 0.
- Advance: adv = !s[DIV_LAT].v | wb_ready_i.
  - When adv=1: every stage shifts, s[k+1] <= s[k] for k=1..DIV_LAT-1, and s[1].v <= 0 unless a divide is inserted.
  - When adv=0: all stages hold.
- Insertion slot for a multiply: K = DIV_LAT-MUL_LAT+1.
  - Divide: written into s[1].
  - Multiply: written into s[K], replacing the shifted-in s[K-1] content.
- ready_o = adv & (is_div_i | !s[K-1].v), combinational.
  - A multiply is refused when an older packet would collide with it in s[K].
  - Divides are never refused except by stall.
- Latency with no stall: a packet accepted in cycle t shows valid_o=1 in cycle t+MUL_LAT (multiply) or t+DIV_LAT (divide).
- Stall: each stall cycle adds one cycle of latency. Packet order at the output always equals order of arrival in s[DIV_LAT]; a multiply may overtake an older divide.
- Output transfer: happens when valid_o & wb_ready_i. valid_o and data stay stable while valid_o=1 & wb_ready_i=0.
- flush_i=1 at an edge:
  - All s[k].v <= 0; data fields are don't-care.
  - Any input that handshakes in the same cycle is discarded.
  - An output transfer in the flush cycle still counts as delivered.
  - valid_o=0 from the next cycle.
- Flush has priority over shift and insert.
- busy_o = OR of all s[k].v.
- Fields are passed through unmodified; no arithmetic is done in this block.

Decomposition:
- Shared package: the writeback packet struct {result, flags, tag, alid}, the FLAG bit positions (executed, exception, mispredict), and DATA_W/TAG_W/ALID_W defaults shared with the ALU and writeback stages.
- One natural sub-module: wb_pipe_stage, a single register slot with hold, load-from-previous, load-from-input and clear controls, instantiated DIV_LAT times.

Test Plan:
1. Multiply, no stall:
   - Stimulus: reset, then at cycle 0 send valid_i=1, is_div_i=0, result_i=64'h0000_0000_0000_0006, tag_i=5, alid_i=9, with wb_ready_i=1.
   - Response: valid_o=1 only in cycle 3 with matching fields; busy_o falls in cycle 4.
2. Divide then multiply:
   - Stimulus: divide (tag 1) at cycle 0, multiply (tag 2) at cycle 1.
   - Response: tag 2 is output at cycle 4 and tag 1 at cycle 8; ready_o=1 both cycles.
3. Collision:
   - Stimulus: divide at cycle 0, multiply offered at cycle 5, when the divide sits in s[K-1]=s[5].
   - Response: ready_o=0 at cycle 5; the multiply is accepted at cycle 6 and output at cycle 9, after the divide at cycle 8.
4. Backpressure:
   - Stimulus: wb_ready_i=0 for cycles 3..6 with a multiply accepted at cycle 0.
   - Response: valid_o=1 and fields stable in cycles 3..7; transfer at cycle 7; ready_o=0 during cycles 3..6.
5. Flush:
   - Stimulus: three packets in flight, flush_i=1 at cycle 4 while valid_i=1 with tag 7.
   - Response: valid_o=0 and busy_o=0 from cycle 5; tag 7 is never output.
6. Async reset mid-operation:
   - Stimulus: reset_n driven to 0 between clock edges with packets in flight.
   - Response: valid_o=0 immediately; after release, no stale packet appears.
